// File: rtl/alu_sequencer.sv
// Round-robin front end for a shared registered calculator: accepts one operation
// from either of two requesters, holds the operands for the datapath latency, returns the tagged result.
module alu_sequencer #(
    parameter int N   = 16,
    parameter int LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_z,
    input  logic [N-1:0] req0_y,
    input  logic [1:0]   req0_mode,
    input  logic [1:0]   req0_btn,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_z,
    input  logic [N-1:0] req1_y,
    input  logic [1:0]   req1_mode,
    input  logic [1:0]   req1_btn,
    output logic [N-1:0] alu_z,
    output logic [N-1:0] alu_y,
    output logic [1:0]   alu_mode,
    output logic [1:0]   alu_btn,
    input  logic [N-1:0] alu_result,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_result,
    output logic         busy
);
    localparam int CW = (LAT < 1) ? 1 : $clog2(LAT + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef struct packed {
        logic [N-1:0] z;
        logic [N-1:0] y;
        logic [1:0]   mode;
        logic [1:0]   btn;
    } op_t;

    op_t [1:0]   req_op;
    logic [1:0]  req_vld;
    logic [1:0]  grant;

    logic [1:0]   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         prio_q, prio_d;
    op_t          op_q, op_d;
    logic         id_q, id_d;
    logic [N-1:0] res_q, res_d;

    assign req_op[0] = {req0_z, req0_y, req0_mode, req0_btn};
    assign req_op[1] = {req1_z, req1_y, req1_mode, req1_btn};
    assign req_vld   = {req1_valid, req0_valid};

    // A lone requester always wins; on a tie prio_q names the winner.
    assign grant[0] = req_vld[0] & (~req_vld[1] | ~prio_q);
    assign grant[1] = req_vld[1] & (~req_vld[0] |  prio_q);

    assign req0_ready = (state_q == ST_IDLE) & grant[0];
    assign req1_ready = (state_q == ST_IDLE) & grant[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prio_d  = prio_q;
        op_d    = op_q;
        id_d    = id_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    op_d    = grant[1] ? req_op[1] : req_op[0];
                    id_d    = grant[1];
                    prio_d  = ~grant[1];
                    cnt_d   = CW'(LAT);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Capture one edge after the counter drains so the result has settled.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    res_d   = alu_result;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            prio_q  <= 1'b0;
            op_q    <= '0;
            id_q    <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prio_q  <= prio_d;
            op_q    <= op_d;
            id_q    <= id_d;
            res_q   <= res_d;
        end
    end

    assign alu_z      = op_q.z;
    assign alu_y      = op_q.y;
    assign alu_mode   = op_q.mode;
    assign alu_btn    = op_q.btn;
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a two-stage registered calculator model.
module tb_alu_sequencer;
    localparam int N   = 16;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [N-1:0] req0_z, req0_y, req1_z, req1_y;
    logic [1:0] req0_mode, req0_btn, req1_mode, req1_btn;
    logic [N-1:0] alu_z, alu_y, alu_result, rsp_result;
    logic [1:0] alu_mode, alu_btn;
    logic rsp_valid, rsp_ready, rsp_id, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.N(N), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_z(req0_z), .req0_y(req0_y),
        .req0_mode(req0_mode), .req0_btn(req0_btn),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_z(req1_z), .req1_y(req1_y),
        .req1_mode(req1_mode), .req1_btn(req1_btn),
        .alu_z(alu_z), .alu_y(alu_y), .alu_mode(alu_mode), .alu_btn(alu_btn),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .busy(busy)
    );

    // Calculator model: two register stages from operands to result, plus a bench override.
    logic [N-1:0] s1 = '0, s2 = '0;
    logic         ovr_en = 1'b0;
    logic [N-1:0] ovr_val = '0;

    function automatic logic [N-1:0] calc(input logic [N-1:0] z, input logic [N-1:0] y,
                                          input logic [1:0] m, input logic [1:0] b);
        logic [N-1:0] r;
        case (m)
            2'd0: r = z + y;
            2'd1: r = z - y;
            2'd2: r = z & y;
            default: r = z ^ y;
        endcase
        return r ^ {b, 14'h0};
    endfunction

    always @(posedge clk) begin
        s1 <= calc(alu_z, alu_y, alu_mode, alu_btn);
        s2 <= s1;
    end
    assign alu_result = ovr_en ? ovr_val : s2;

    typedef struct {
        logic         id;
        logic [N-1:0] z;
        logic [N-1:0] y;
        logic [1:0]   mode;
        logic [1:0]   btn;
        logic [N-1:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic id, input logic v, input logic [N-1:0] z, input logic [N-1:0] y,
                         input logic [1:0] m, input logic [1:0] b);
        if (id == 1'b0) begin
            req0_valid = v; req0_z = z; req0_y = y; req0_mode = m; req0_btn = b;
        end else begin
            req1_valid = v; req1_z = z; req1_y = y; req1_mode = m; req1_btn = b;
        end
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: got no rsp_valid in %0d cycles expected within %0d", n, LAT + 2);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int gcyc[$];
        int gid[$];
        int rid[$];
        logic both_ready;
        logic first_id;
        logic [N-1:0] first_res;
        logic seen;

        vecs[0] = '{1'b0, 16'h0005, 16'h0003, 2'd0, 2'd0, 16'h0008};
        vecs[1] = '{1'b1, 16'h00FF, 16'h0001, 2'd0, 2'd0, 16'h0100};
        vecs[2] = '{1'b0, 16'h0010, 16'h0003, 2'd1, 2'd0, 16'h000D};
        vecs[3] = '{1'b1, 16'h00F0, 16'h003C, 2'd2, 2'd0, 16'h0030};
        vecs[4] = '{1'b0, 16'h1234, 16'h00FF, 2'd3, 2'd0, 16'h12CB};
        vecs[5] = '{1'b1, 16'h0001, 16'h0002, 2'd0, 2'd1, 16'h4003};
        vecs[6] = '{1'b0, 16'h0000, 16'h0001, 2'd1, 2'd2, 16'h7FFF};
        vecs[7] = '{1'b1, 16'hFFFF, 16'h0001, 2'd0, 2'd0, 16'h0000};

        rst = 1'b0;
        rsp_ready = 1'b0;
        drive(1'b0, 1'b0, '0, '0, 2'd0, 2'd0);
        drive(1'b1, 1'b0, '0, '0, 2'd0, 2'd0);
        #12;
        chk("reset_alu", {alu_z, alu_y, alu_mode, alu_btn}, 64'h0);
        chk("reset_rsp", {rsp_valid, rsp_id, busy, rsp_result}, 64'h0);
        step();
        rst = 1'b1;

        // Single-requester operations, one table row at a time.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].id, 1'b1, vecs[i].z, vecs[i].y, vecs[i].mode, vecs[i].btn);
            #1;
            chk($sformatf("v%0d_ready", i), {req1_ready, req0_ready}, vecs[i].id ? 2'b10 : 2'b01);
            chk($sformatf("v%0d_idle_busy", i), busy, 1'b0);
            step();
            drive(vecs[i].id, 1'b0, '0, '0, 2'd0, 2'd0);
            chk($sformatf("v%0d_alu", i), {alu_z, alu_y, alu_mode, alu_btn},
                {vecs[i].z, vecs[i].y, vecs[i].mode, vecs[i].btn});
            chk($sformatf("v%0d_busy", i), {busy, rsp_valid}, 2'b10);
            wait_rsp(n);
            chk($sformatf("v%0d_latency", i), 1 + n, LAT + 2);
            chk($sformatf("v%0d_rsp", i), {rsp_id, rsp_result}, {vecs[i].id, vecs[i].exp});
            chk($sformatf("v%0d_alu_held", i), alu_z, vecs[i].z);
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            chk($sformatf("v%0d_idle", i), {rsp_valid, busy}, 2'b00);
        end

        // Both requesters continuously valid: strict alternation, five cycles apart.
        do_reset();
        drive(1'b0, 1'b1, 16'h0002, 16'h0003, 2'd0, 2'd0);
        drive(1'b1, 1'b1, 16'h0009, 16'h0001, 2'd0, 2'd0);
        rsp_ready = 1'b1;
        both_ready = 1'b0;
        #1;
        for (int c = 0; c < 20; c++) begin
            if (req0_ready && req1_ready) both_ready = 1'b1;
            if (req0_ready) begin gcyc.push_back(c); gid.push_back(0); end
            if (req1_ready) begin gcyc.push_back(c); gid.push_back(1); end
            if (rsp_valid) begin
                rid.push_back(int'(rsp_id));
                chk($sformatf("rr_result_c%0d", c), rsp_result, rsp_id ? 16'h000A : 16'h0005);
            end
            step();
        end
        drive(1'b0, 1'b0, '0, '0, 2'd0, 2'd0);
        drive(1'b1, 1'b0, '0, '0, 2'd0, 2'd0);
        rsp_ready = 1'b0;
        chk("rr_both_ready", both_ready, 1'b0);
        chk("rr_grant_count", gid.size(), 4);
        for (int k = 0; k < gid.size(); k++) begin
            chk($sformatf("rr_grant%0d_id", k), gid[k], k % 2);
            chk($sformatf("rr_grant%0d_cycle", k), gcyc[k], 5 * k);
        end
        chk("rr_rsp_count", rid.size(), 4);
        for (int k = 0; k < rid.size(); k++)
            chk($sformatf("rr_rsp%0d_id", k), rid[k], k % 2);

        // req1 alone, then a tie: prio has returned to req0.
        drive(1'b1, 1'b1, 16'h00FF, 16'h0001, 2'd0, 2'd0);
        #1;
        chk("tie_req1_first", {req1_ready, req0_ready}, 2'b10);
        step();
        drive(1'b1, 1'b1, 16'h0004, 16'h0001, 2'd1, 2'd0);
        drive(1'b0, 1'b1, 16'h0006, 16'h0002, 2'd2, 2'd0);
        rsp_ready = 1'b1;
        seen = 1'b0;
        first_id = 1'b0;
        first_res = '0;
        n = 0;
        while (!(req0_ready || req1_ready) && n < 20) begin
            if (rsp_valid && !seen) begin
                seen = 1'b1; first_id = rsp_id; first_res = rsp_result;
            end
            step();
            n++;
        end
        chk("tie_first_rsp", {seen, first_id, first_res}, {1'b1, 1'b1, 16'h0100});
        chk("tie_grant_req0", {req1_ready, req0_ready}, 2'b01);
        rsp_ready = 1'b0;
        step();
        drive(1'b0, 1'b0, '0, '0, 2'd0, 2'd0);
        drive(1'b1, 1'b0, '0, '0, 2'd0, 2'd0);
        wait_rsp(n);
        chk("tie_second_rsp", {rsp_id, rsp_result}, {1'b0, 16'h0002});
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Response backpressure: everything held, nothing accepted.
        drive(1'b0, 1'b1, 16'h0007, 16'h0002, 2'd1, 2'd0);
        #1;
        chk("bp_accept", req0_ready, 1'b1);
        step();
        drive(1'b0, 1'b0, '0, '0, 2'd0, 2'd0);
        drive(1'b1, 1'b1, 16'h0001, 16'h0001, 2'd0, 2'd0);
        wait_rsp(n);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("bp_hold%0d", k), {rsp_valid, rsp_id, rsp_result, req1_ready, req0_ready},
                {1'b1, 1'b0, 16'h0005, 2'b00});
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_still_held", {rsp_valid, req1_ready}, 2'b10);
        step();
        rsp_ready = 1'b0;
        chk("bp_idle", {rsp_valid, busy, req1_ready}, 3'b001);
        drive(1'b1, 1'b0, '0, '0, 2'd0, 2'd0);

        // Asynchronous reset while waiting with cnt==1.
        drive(1'b0, 1'b1, 16'h00AA, 16'h0055, 2'd3, 2'd1);
        #1;
        chk("ar_accept", req0_ready, 1'b1);
        step();
        drive(1'b0, 1'b0, '0, '0, 2'd0, 2'd0);
        step();
        chk("ar_pre_alu", alu_z, 16'h00AA);
        rst = 1'b0;
        #1;
        chk("ar_alu_zero", {alu_z, alu_y, alu_mode, alu_btn}, 64'h0);
        chk("ar_rsp_zero", {rsp_valid, rsp_id, busy, rsp_result}, 64'h0);
        step();
        step();
        rst = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (rsp_valid || busy) seen = 1'b1;
            step();
        end
        chk("ar_no_rsp", seen, 1'b0);
        drive(1'b0, 1'b1, 16'h0000, 16'h0000, 2'd0, 2'd0);
        drive(1'b1, 1'b1, 16'h0100, 16'h0020, 2'd1, 2'd0);
        #1;
        chk("ar_tie_req0", {req1_ready, req0_ready}, 2'b01);
        drive(1'b0, 1'b0, '0, '0, 2'd0, 2'd0);
        #1;
        chk("ar_req1_alone", {req1_ready, req0_ready}, 2'b10);
        step();
        drive(1'b1, 1'b0, '0, '0, 2'd0, 2'd0);
        wait_rsp(n);
        chk("ar_req1_rsp", {rsp_id, rsp_result}, {1'b1, 16'h00E0});
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Datapath result moving during WAIT: the value at the cnt==0 edge wins.
        drive(1'b0, 1'b1, 16'h0001, 16'h0001, 2'd0, 2'd0);
        #1;
        chk("cap_accept", req0_ready, 1'b1);
        step();
        drive(1'b0, 1'b0, '0, '0, 2'd0, 2'd0);
        ovr_en = 1'b1;
        ovr_val = 16'h1111;
        step();
        ovr_val = 16'h2222;
        step();
        ovr_val = 16'h3333;
        step();
        ovr_val = 16'h4444;
        #1;
        chk("cap_result", {rsp_valid, rsp_result}, {1'b1, 16'h3333});
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        ovr_en = 1'b0;
        chk("cap_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
